// File: rtl/axi_bridge_pkg.sv
// axi_bridge_pkg: AXI response/burst constants and bridge FSM state type.
package axi_bridge_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, RD_DATA, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
    } state_t;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: holds the current beat address and remaining beat count of a burst.
module axi_burst_addr_gen
    import axi_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              next,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_len,
    input  logic [1:0]        load_burst,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        beats_left,
    output logic              last
);
    logic fixed;

    // WRAP is treated like INCR: word-align, then step one word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= '0;
            beats_left <= '0;
            fixed      <= 1'b0;
        end else if (load) begin
            addr       <= load_addr;
            beats_left <= load_len;
            fixed      <= load_burst == BURST_FIXED;
        end else if (next) begin
            addr       <= fixed ? addr : {addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
            beats_left <= beats_left - 8'd1;
        end
    end

    assign last = beats_left == 8'd0;
endmodule

// File: rtl/axi2core.sv
// axi2core: AXI4 slave that replays each burst beat as one request on a req/gnt/rvalid memory port.
module axi2core
    import axi_bridge_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]                    aw_len_i,
    input  logic [2:0]                    aw_size_i,
    input  logic [1:0]                    aw_burst_i,
    input  logic                          aw_lock_i,
    input  logic [3:0]                    aw_cache_i,
    input  logic [2:0]                    aw_prot_i,
    input  logic [3:0]                    aw_region_i,
    input  logic [AXI4_USER_WIDTH-1:0]    aw_user_i,
    input  logic [3:0]                    aw_qos_i,
    input  logic                          aw_valid_i,
    output logic                          aw_ready_o,
    input  logic [31:0]                   w_data_i,
    input  logic [3:0]                    w_strb_i,
    input  logic                          w_last_i,
    input  logic [AXI4_USER_WIDTH-1:0]    w_user_i,
    input  logic                          w_valid_i,
    output logic                          w_ready_o,
    output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
    output logic [1:0]                    b_resp_o,
    output logic [AXI4_USER_WIDTH-1:0]    b_user_o,
    output logic                          b_valid_o,
    input  logic                          b_ready_i,
    input  logic [AXI4_ID_WIDTH-1:0]      ar_id_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]                    ar_len_i,
    input  logic [2:0]                    ar_size_i,
    input  logic [1:0]                    ar_burst_i,
    input  logic                          ar_lock_i,
    input  logic [3:0]                    ar_cache_i,
    input  logic [2:0]                    ar_prot_i,
    input  logic [3:0]                    ar_region_i,
    input  logic [AXI4_USER_WIDTH-1:0]    ar_user_i,
    input  logic [3:0]                    ar_qos_i,
    input  logic                          ar_valid_i,
    output logic                          ar_ready_o,
    output logic [AXI4_ID_WIDTH-1:0]      r_id_o,
    output logic [31:0]                   r_data_o,
    output logic [1:0]                    r_resp_o,
    output logic                          r_last_o,
    output logic [AXI4_USER_WIDTH-1:0]    r_user_o,
    output logic                          r_valid_o,
    input  logic                          r_ready_i,
    output logic                          mem_req_o,
    input  logic                          mem_gnt_i,
    output logic [AXI4_ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic                          mem_we_o,
    output logic [3:0]                    mem_be_o,
    output logic [31:0]                   mem_wdata_o,
    input  logic                          mem_rvalid_i,
    input  logic [31:0]                   mem_rdata_i
);
    state_t                   state;
    logic                     prio_wr;
    logic [AXI4_ID_WIDTH-1:0] id_q;
    logic [31:0]              rdata_q, wdata_q;
    logic [3:0]               strb_q;
    logic [7:0]               beats_left;
    logic                     last, next;
    logic                     unused_ok;

    // on a tie the channel not served last wins; prio_wr=0 means read goes first
    assign ar_ready_o = state == IDLE && ar_valid_i && !(aw_valid_i && prio_wr);
    assign aw_ready_o = state == IDLE && aw_valid_i && !(ar_valid_i && !prio_wr);
    assign next = (state == RD_DATA && r_ready_i && !last) ||
                  (state == WR_WAIT && mem_rvalid_i && !last);

    axi_burst_addr_gen #(.ADDR_W(AXI4_ADDRESS_WIDTH)) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (ar_ready_o || aw_ready_o),
        .next       (next),
        .load_addr  (ar_ready_o ? ar_addr_i : aw_addr_i),
        .load_len   (ar_ready_o ? ar_len_i : aw_len_i),
        .load_burst (ar_ready_o ? ar_burst_i : aw_burst_i),
        .addr       (mem_addr_o),
        .beats_left (beats_left),
        .last       (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            prio_wr <= 1'b0;
            id_q    <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            case (state)
                IDLE:
                    if (ar_ready_o) begin
                        id_q    <= ar_id_i;
                        prio_wr <= 1'b1;
                        state   <= RD_REQ;
                    end else if (aw_ready_o) begin
                        id_q    <= aw_id_i;
                        prio_wr <= 1'b0;
                        state   <= WR_DATA;
                    end
                RD_REQ:  if (mem_gnt_i) state <= RD_WAIT;
                RD_WAIT:
                    if (mem_rvalid_i) begin
                        rdata_q <= mem_rdata_i;
                        state   <= RD_DATA;
                    end
                RD_DATA: if (r_ready_i) state <= last ? IDLE : RD_REQ;
                WR_DATA:
                    if (w_valid_i) begin
                        wdata_q <= w_data_i;
                        strb_q  <= w_strb_i;
                        state   <= WR_REQ;
                    end
                WR_REQ:  if (mem_gnt_i) state <= WR_WAIT;
                WR_WAIT: if (mem_rvalid_i) state <= last ? WR_RESP : WR_DATA;
                WR_RESP: if (b_ready_i) state <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = state == RD_REQ || state == WR_REQ;
    assign mem_we_o    = state == WR_REQ;
    assign mem_be_o    = state == RD_REQ ? 4'hF : state == WR_REQ ? strb_q : 4'h0;
    assign mem_wdata_o = wdata_q;
    assign w_ready_o   = state == WR_DATA;
    assign r_valid_o   = state == RD_DATA;
    assign r_last_o    = state == RD_DATA && last;
    assign r_data_o    = rdata_q;
    assign r_id_o      = id_q;
    assign r_resp_o    = RESP_OKAY;
    assign r_user_o    = '0;
    assign b_valid_o   = state == WR_RESP;
    assign b_id_o      = id_q;
    assign b_resp_o    = RESP_OKAY;
    assign b_user_o    = '0;

    assign unused_ok = ^{aw_size_i, aw_lock_i, aw_cache_i, aw_prot_i, aw_region_i, aw_user_i, aw_qos_i,
                         ar_size_i, ar_lock_i, ar_cache_i, ar_prot_i, ar_region_i, ar_user_i, ar_qos_i,
                         w_last_i, w_user_i};
endmodule

// File: tb/tb_axi2core.sv
// tb_axi2core: directed bench for axi2core with a zero/configurable-wait memory model.
module tb_axi2core;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] aw_id_i, ar_id_i, b_id_o, r_id_o;
    logic [31:0] aw_addr_i, ar_addr_i, w_data_i, r_data_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [7:0]  aw_len_i, ar_len_i;
    logic [2:0]  aw_size_i, ar_size_i, aw_prot_i, ar_prot_i;
    logic [1:0]  aw_burst_i, ar_burst_i, b_resp_o, r_resp_o;
    logic        aw_lock_i, ar_lock_i;
    logic [3:0]  aw_cache_i, ar_cache_i, aw_region_i, ar_region_i, aw_qos_i, ar_qos_i;
    logic [9:0]  aw_user_i, ar_user_i, w_user_i, b_user_o, r_user_o;
    logic        aw_valid_i, aw_ready_o, ar_valid_i, ar_ready_o;
    logic [3:0]  w_strb_i, mem_be_o;
    logic        w_last_i, w_valid_i, w_ready_o, b_valid_o, b_ready_i;
    logic        r_last_o, r_valid_o, r_ready_i;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;

    int errors = 0, checks = 0;
    int gnt_delay = 0, stall = 0, log_n = 0, base;
    logic [31:0] log_addr [0:511];
    logic [31:0] log_wdata [0:511];
    logic [3:0]  log_be [0:511];
    logic        log_we [0:511];
    logic [31:0] d;
    logic        l;
    logic [15:0] rid;

    always #5 clk = ~clk;

    axi2core dut (
        .clk(clk), .rst_n(rst_n),
        .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
        .aw_burst_i(aw_burst_i), .aw_lock_i(aw_lock_i), .aw_cache_i(aw_cache_i), .aw_prot_i(aw_prot_i),
        .aw_region_i(aw_region_i), .aw_user_i(aw_user_i), .aw_qos_i(aw_qos_i), .aw_valid_i(aw_valid_i),
        .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i), .w_user_i(w_user_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_user_o(b_user_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
        .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
        .ar_burst_i(ar_burst_i), .ar_lock_i(ar_lock_i), .ar_cache_i(ar_cache_i), .ar_prot_i(ar_prot_i),
        .ar_region_i(ar_region_i), .ar_user_i(ar_user_i), .ar_qos_i(ar_qos_i), .ar_valid_i(ar_valid_i),
        .ar_ready_o(ar_ready_o),
        .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_user_o(r_user_o),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
    endfunction

    // memory model: grant after gnt_delay stalled cycles, rvalid one cycle after grant
    assign mem_gnt_i = mem_req_o && stall >= gnt_delay;
    always @(posedge clk) begin
        stall        <= (mem_req_o && !mem_gnt_i) ? stall + 1 : 0;
        mem_rvalid_i <= mem_req_o && mem_gnt_i;
        mem_rdata_i  <= mem_val(mem_addr_o);
        if (mem_req_o && mem_gnt_i && log_n < 512) begin
            log_addr[log_n]  <= mem_addr_o;
            log_wdata[log_n] <= mem_wdata_o;
            log_be[log_n]    <= mem_be_o;
            log_we[log_n]    <= mem_we_o;
            log_n            <= log_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic set_ar(input logic [15:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
        ar_id_i = id; ar_addr_i = a; ar_len_i = len; ar_burst_i = bt; ar_valid_i = 1'b1;
    endtask

    task automatic set_aw(input logic [15:0] id, input logic [31:0] a, input logic [7:0] len, input logic [1:0] bt);
        aw_id_i = id; aw_addr_i = a; aw_len_i = len; aw_burst_i = bt; aw_valid_i = 1'b1;
    endtask

    task automatic hs_ar();
        int n = 0;
        #1;
        while (!ar_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("ar_ready_timeout", ar_ready_o, 1);
        @(posedge clk); #1;
        ar_valid_i = 1'b0;
    endtask

    task automatic hs_aw();
        int n = 0;
        #1;
        while (!aw_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("aw_ready_timeout", aw_ready_o, 1);
        @(posedge clk); #1;
        aw_valid_i = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        w_data_i = data; w_strb_i = strb; w_valid_i = 1'b1;
        #1;
        while (!w_ready_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("w_ready_timeout", w_ready_o, 1);
        @(posedge clk); #1;
        w_valid_i = 1'b0;
    endtask

    task automatic r_get(input int hold, output logic [31:0] data, output logic last, output logic [15:0] id);
        int n = 0;
        while (!r_valid_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("r_valid_timeout", r_valid_o, 1);
        data = r_data_o;
        repeat (hold) begin
            @(posedge clk); #1;
            chk("r_hold_data", r_data_o, data);
            chk("r_hold_valid", r_valid_o, 1);
        end
        chk("r_resp", r_resp_o, 0);
        last = r_last_o; id = r_id_o;
        r_ready_i = 1'b1;
        @(posedge clk); #1;
        r_ready_i = 1'b0;
    endtask

    task automatic b_get(input logic [15:0] id);
        int n = 0;
        while (!b_valid_o && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) chk("b_valid_timeout", b_valid_o, 1);
        chk("b_id", b_id_o, id);
        chk("b_resp", b_resp_o, 0);
        b_ready_i = 1'b1;
        @(posedge clk); #1;
        b_ready_i = 1'b0;
        chk("b_valid_drop", b_valid_o, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        {aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i, aw_lock_i, aw_cache_i, aw_prot_i} = '0;
        {aw_region_i, aw_user_i, aw_qos_i, aw_valid_i} = '0;
        {ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i, ar_lock_i, ar_cache_i, ar_prot_i} = '0;
        {ar_region_i, ar_user_i, ar_qos_i, ar_valid_i} = '0;
        {w_data_i, w_strb_i, w_last_i, w_user_i, w_valid_i, b_ready_i, r_ready_i} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_b_valid", b_valid_o, 0);
        chk("rst_w_ready", w_ready_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chk("rst_r_data", r_data_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-beat read with cycle-exact latency
        set_ar(16'h1234, 32'h100, 8'd0, 2'd1);
        hs_ar();
        chk("rd1_req_c1", mem_req_o, 1);
        chk("rd1_addr", mem_addr_o, 32'h100);
        chk("rd1_we", mem_we_o, 0);
        chk("rd1_be", mem_be_o, 4'hF);
        @(posedge clk); #1;
        chk("rd1_rvalid_c2", mem_rvalid_i, 1);
        chk("rd1_no_r_c2", r_valid_o, 0);
        @(posedge clk); #1;
        chk("rd1_r_valid_c3", r_valid_o, 1);
        r_get(0, d, l, rid);
        chk("rd1_data", d, 32'hDEADBEEF);
        chk("rd1_last", l, 1);
        chk("rd1_id", rid, 16'h1234);
        chk("rd1_r_drop", r_valid_o, 0);

        // 4-beat INCR write
        set_aw(16'h0055, 32'h200, 8'd3, 2'd1);
        hs_aw();
        chk("wr_w_ready_c1", w_ready_o, 1);
        base = log_n;
        for (int i = 0; i < 4; i++) begin
            chk("wr_no_b_early", b_valid_o, 0);
            w_send(32'(i + 1), 4'hF);
        end
        b_get(16'h0055);
        repeat (3) @(posedge clk);
        #1 chk("wr_single_b", b_valid_o, 0);
        chk("wr_count", log_n - base, 4);
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr", log_addr[base + i], 32'h200 + 32'(4 * i));
            chk("wr_data", log_wdata[base + i], 32'(i + 1));
            chk("wr_we", 32'(log_we[base + i]), 1);
            chk("wr_be", 32'(log_be[base + i]), 4'hF);
        end

        // arbitration: read first after reset, then write on the next tie
        do_reset();
        set_ar(16'h00A1, 32'h300, 8'd0, 2'd1);
        set_aw(16'h00B1, 32'h340, 8'd0, 2'd1);
        #1;
        chk("arb1_ar_ready", ar_ready_o, 1);
        chk("arb1_aw_ready", aw_ready_o, 0);
        hs_ar();
        r_get(0, d, l, rid);
        chk("arb1_rdata", d, 32'hA5A50300);
        chk("arb1_rid", rid, 16'h00A1);
        set_ar(16'h00A2, 32'h380, 8'd0, 2'd1);
        #1;
        chk("arb2_aw_ready", aw_ready_o, 1);
        chk("arb2_ar_ready", ar_ready_o, 0);
        hs_aw();
        w_send(32'hCAFE, 4'hF);
        b_get(16'h00B1);
        hs_ar();
        r_get(0, d, l, rid);
        chk("arb2_rdata", d, 32'hA5A50380);
        chk("arb2_rid", rid, 16'h00A2);

        // FIXED read with grant stall and R backpressure
        gnt_delay = 3;
        set_ar(16'h0044, 32'h400, 8'd1, 2'd0);
        hs_ar();
        base = log_n;
        for (int k = 0; k < 3; k++) begin
            chk("fix_stall_req", mem_req_o, 1);
            chk("fix_stall_gnt", mem_gnt_i, 0);
            chk("fix_stall_addr", mem_addr_o, 32'h400);
            @(posedge clk); #1;
        end
        r_get(2, d, l, rid);
        chk("fix_b0_data", d, 32'hA5A50400);
        chk("fix_b0_last", l, 0);
        r_get(2, d, l, rid);
        chk("fix_b1_data", d, 32'hA5A50400);
        chk("fix_b1_last", l, 1);
        chk("fix_count", log_n - base, 2);
        chk("fix_b1_addr", log_addr[base + 1], 32'h400);
        gnt_delay = 0;

        // unaligned write, partial strobe then zero strobe
        set_aw(16'h0066, 32'h103, 8'd1, 2'd1);
        hs_aw();
        base = log_n;
        w_send(32'h11, 4'h2);
        w_send(32'h22, 4'h0);
        b_get(16'h0066);
        chk("ua_addr0", log_addr[base], 32'h103);
        chk("ua_be0", 32'(log_be[base]), 4'h2);
        chk("ua_data0", log_wdata[base], 32'h11);
        chk("ua_addr1", log_addr[base + 1], 32'h104);
        chk("ua_be1", 32'(log_be[base + 1]), 4'h0);
        chk("ua_we1", 32'(log_we[base + 1]), 1);

        // reset during the third beat of a len=7 read
        set_ar(16'h0077, 32'h500, 8'd7, 2'd1);
        hs_ar();
        r_get(0, d, l, rid);
        chk("ab_b0_data", d, 32'hA5A50500);
        r_get(0, d, l, rid);
        chk("ab_b1_data", d, 32'hA5A50504);
        chk("ab_b2_req", mem_req_o, 1);
        chk("ab_b2_addr", mem_addr_o, 32'h508);
        rst_n = 1'b0;
        #1;
        chk("ab_rst_req", mem_req_o, 0);
        chk("ab_rst_addr", mem_addr_o, 0);
        chk("ab_rst_rdata", r_data_o, 0);
        chk("ab_rst_rid", r_id_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("ab_no_r", r_valid_o, 0);
        end
        set_ar(16'h0088, 32'h600, 8'd0, 2'd1);
        hs_ar();
        r_get(0, d, l, rid);
        chk("ab_new_data", d, 32'hA5A50600);
        chk("ab_new_id", rid, 16'h0088);
        chk("ab_new_last", l, 1);

        // maximum burst: 256 beats
        begin
            int bad = 0;
            set_ar(16'h0007, 32'h1000, 8'd255, 2'd1);
            hs_ar();
            base = log_n;
            for (int i = 0; i < 256; i++) begin
                r_get(0, d, l, rid);
                if (d !== {16'hA5A5, 16'(32'h1000 + 32'(4 * i))}) bad++;
                if (l !== (i == 255)) bad++;
            end
            chk("b256_bad_beats", bad, 0);
            chk("b256_count", log_n - base, 256);
            chk("b256_last_addr", log_addr[base + 255], 32'h13FC);
            repeat (2) @(posedge clk);
            #1 chk("b256_idle", r_valid_o, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
